// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module      : regfile_mp
// Description : Multi-ported register file with one write port, two
//               independent combinational read ports and per-register
//               pending (scoreboard) bits with a reserve-collision flag.
//               Same-cycle write-to-read forwarding is enabled by defining
//               REGFILE_MP_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_mp #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic [ADDR_W-1:0] writenum,
    input  logic              write,
    input  logic [ADDR_W-1:0] readnum_a,
    input  logic [ADDR_W-1:0] readnum_b,
    output logic [DATA_W-1:0] data_out_a,
    output logic [DATA_W-1:0] data_out_b,
    input  logic              rsv,
    input  logic [ADDR_W-1:0] rsvnum,
    output logic              busy_a,
    output logic              busy_b,
    output logic              rsv_err
);

    localparam int c_num_regs = 2 ** ADDR_W;

    logic [DATA_W-1:0]     r_regs [c_num_regs];
    logic [c_num_regs-1:0] r_pending;
    logic                  r_rsv_err;

    logic [c_num_regs-1:0] w_pending_nxt;
    logic                  w_rsv_err_nxt;

    // Clear-then-set ordering gives the reserve priority when both name the same register.
    always_comb begin
        w_pending_nxt = r_pending;
        if (write) begin
            w_pending_nxt[writenum] = 1'b0;
        end
        if (rsv) begin
            w_pending_nxt[rsvnum] = 1'b1;
        end
    end

    assign w_rsv_err_nxt = rsv && r_pending[rsvnum] && !(write && (writenum == rsvnum));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < c_num_regs; i++) begin
                r_regs[i] <= '0;
            end
            r_pending <= '0;
            r_rsv_err <= 1'b0;
        end else begin
            if (write) begin
                r_regs[writenum] <= data_in;
            end
            r_pending <= w_pending_nxt;
            r_rsv_err <= w_rsv_err_nxt;
        end
    end

    assign rsv_err = r_rsv_err;

`ifdef REGFILE_MP_BYPASS_EN
    logic w_hit_a;
    logic w_hit_b;

    // A write landing this cycle completes the producer, so the reader sees it as not busy.
    assign w_hit_a    = write && (writenum == readnum_a);
    assign w_hit_b    = write && (writenum == readnum_b);
    assign data_out_a = w_hit_a ? data_in : r_regs[readnum_a];
    assign data_out_b = w_hit_b ? data_in : r_regs[readnum_b];
    assign busy_a     = !w_hit_a && r_pending[readnum_a];
    assign busy_b     = !w_hit_b && r_pending[readnum_b];
`else
    assign data_out_a = r_regs[readnum_a];
    assign data_out_b = r_regs[readnum_b];
    assign busy_a     = r_pending[readnum_a];
    assign busy_b     = r_pending[readnum_b];
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// Directed testbench for regfile_mp: reset, dual read, scoreboard,
// simultaneous reserve/write, double reserve and forwarding behaviour.
module tb_regfile_mp;

    logic        clk;
    logic        reset;
    logic [15:0] data_in;
    logic [2:0]  writenum;
    logic        write;
    logic [2:0]  readnum_a;
    logic [2:0]  readnum_b;
    logic [15:0] data_out_a;
    logic [15:0] data_out_b;
    logic        rsv;
    logic [2:0]  rsvnum;
    logic        busy_a;
    logic        busy_b;
    logic        rsv_err;

    int n_pass  = 0;
    int n_total = 0;

    regfile_mp #(.DATA_W(16), .ADDR_W(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .writenum   (writenum),
        .write      (write),
        .readnum_a  (readnum_a),
        .readnum_b  (readnum_b),
        .data_out_a (data_out_a),
        .data_out_b (data_out_b),
        .rsv        (rsv),
        .rsvnum     (rsvnum),
        .busy_a     (busy_a),
        .busy_b     (busy_b),
        .rsv_err    (rsv_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past one rising edge, then drop the strobes so later reads see stored state.
    task automatic tick();
        @(posedge clk);
        #1;
        write = 1'b0;
        rsv   = 1'b0;
        #1;
    endtask

    task automatic do_write(input logic [2:0] idx, input logic [15:0] val);
        write = 1'b1; writenum = idx; data_in = val;
        tick();
    endtask

    task automatic do_rsv(input logic [2:0] idx);
        rsv = 1'b1; rsvnum = idx;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2;
        n_total++; if (data_out_a !== 16'h0000) $display("FAIL reset_data_a: got %h expected %h", data_out_a, 16'h0000); else n_pass++;
        n_total++; if (busy_b !== 1'b0) $display("FAIL reset_busy_b: got %b expected %b", busy_b, 1'b0); else n_pass++;
        n_total++; if (rsv_err !== 1'b0) $display("FAIL reset_rsv_err: got %b expected %b", rsv_err, 1'b0); else n_pass++;
        tick();
        reset = 1'b0;
        #1;
        // Mid-operation reset: R3 written, R5 double-reserved (rsv_err high), then async reset.
        do_write(3'd3, 16'h1234);
        do_rsv(3'd5);
        do_rsv(3'd5);
        readnum_a = 3'd3;
        #1;
        n_total++; if (data_out_a !== 16'h1234) $display("FAIL pre_reset_r3: got %h expected %h", data_out_a, 16'h1234); else n_pass++;
        n_total++; if (rsv_err !== 1'b1) $display("FAIL pre_reset_rsv_err: got %b expected %b", rsv_err, 1'b1); else n_pass++;
        reset = 1'b1;
        #1;
        n_total++; if (data_out_a !== 16'h0000) $display("FAIL midreset_r3: got %h expected %h", data_out_a, 16'h0000); else n_pass++;
        n_total++; if (rsv_err !== 1'b0) $display("FAIL midreset_rsv_err: got %b expected %b", rsv_err, 1'b0); else n_pass++;
        readnum_a = 3'd5;
        #1;
        n_total++; if (busy_a !== 1'b0) $display("FAIL midreset_busy_r5: got %b expected %b", busy_a, 1'b0); else n_pass++;
        // Strobes across an edge while reset is held must be ignored.
        write = 1'b1; writenum = 3'd3; data_in = 16'hFFFF;
        rsv = 1'b1; rsvnum = 3'd3;
        @(posedge clk);
        #1;
        reset = 1'b0; write = 1'b0; rsv = 1'b0;
        readnum_a = 3'd3;
        #1;
        n_total++; if (data_out_a !== 16'h0000) $display("FAIL reset_ignores_write: got %h expected %h", data_out_a, 16'h0000); else n_pass++;
        n_total++; if (busy_a !== 1'b0) $display("FAIL reset_ignores_rsv: got %b expected %b", busy_a, 1'b0); else n_pass++;
    endtask

    task automatic test_dual_read();
        do_write(3'd1, 16'hAAAA);
        do_write(3'd6, 16'h5555);
        readnum_a = 3'd1; readnum_b = 3'd6;
        #1;
        n_total++; if (data_out_a !== 16'hAAAA) $display("FAIL dual_a_r1: got %h expected %h", data_out_a, 16'hAAAA); else n_pass++;
        n_total++; if (data_out_b !== 16'h5555) $display("FAIL dual_b_r6: got %h expected %h", data_out_b, 16'h5555); else n_pass++;
        readnum_a = 3'd6;
        #1;
        n_total++; if (data_out_a !== 16'h5555) $display("FAIL same_idx_a: got %h expected %h", data_out_a, 16'h5555); else n_pass++;
        n_total++; if (data_out_b !== 16'h5555) $display("FAIL same_idx_b: got %h expected %h", data_out_b, 16'h5555); else n_pass++;
    endtask

    task automatic test_scoreboard();
        do_rsv(3'd2);
        readnum_a = 3'd2;
        #1;
        n_total++; if (busy_a !== 1'b1) $display("FAIL sb_busy_set: got %b expected %b", busy_a, 1'b1); else n_pass++;
        n_total++; if (rsv_err !== 1'b0) $display("FAIL sb_no_err: got %b expected %b", rsv_err, 1'b0); else n_pass++;
        do_write(3'd2, 16'h00FF);
        n_total++; if (busy_a !== 1'b0) $display("FAIL sb_busy_clr: got %b expected %b", busy_a, 1'b0); else n_pass++;
        n_total++; if (data_out_a !== 16'h00FF) $display("FAIL sb_data: got %h expected %h", data_out_a, 16'h00FF); else n_pass++;
    endtask

    task automatic test_simultaneous();
        do_rsv(3'd4);
        rsv = 1'b1; rsvnum = 3'd4;
        write = 1'b1; writenum = 3'd4; data_in = 16'hBEEF;
        tick();
        readnum_b = 3'd4;
        #1;
        n_total++; if (data_out_b !== 16'hBEEF) $display("FAIL simul_data: got %h expected %h", data_out_b, 16'hBEEF); else n_pass++;
        n_total++; if (busy_b !== 1'b1) $display("FAIL simul_busy: got %b expected %b", busy_b, 1'b1); else n_pass++;
        n_total++; if (rsv_err !== 1'b0) $display("FAIL simul_rsv_err: got %b expected %b", rsv_err, 1'b0); else n_pass++;
    endtask

    task automatic test_double_reserve();
        readnum_a = 3'd7;
        do_rsv(3'd7);
        n_total++; if (rsv_err !== 1'b0) $display("FAIL dbl_first_err: got %b expected %b", rsv_err, 1'b0); else n_pass++;
        n_total++; if (busy_a !== 1'b1) $display("FAIL dbl_busy: got %b expected %b", busy_a, 1'b1); else n_pass++;
        do_rsv(3'd7);
        n_total++; if (rsv_err !== 1'b1) $display("FAIL dbl_second_err: got %b expected %b", rsv_err, 1'b1); else n_pass++;
        tick();
        n_total++; if (rsv_err !== 1'b0) $display("FAIL dbl_err_pulse: got %b expected %b", rsv_err, 1'b0); else n_pass++;
        n_total++; if (busy_a !== 1'b1) $display("FAIL dbl_still_busy: got %b expected %b", busy_a, 1'b1); else n_pass++;
    endtask

    task automatic test_bypass();
        logic [15:0] exp_pre;
`ifdef REGFILE_MP_BYPASS_EN
        exp_pre = 16'h0002;
`else
        exp_pre = 16'h0001;
`endif
        do_write(3'd0, 16'h0001);
        readnum_a = 3'd0; readnum_b = 3'd1;
        write = 1'b1; writenum = 3'd0; data_in = 16'h0002;
        #1;
        n_total++; if (data_out_a !== exp_pre) $display("FAIL bypass_pre_edge: got %h expected %h", data_out_a, exp_pre); else n_pass++;
        n_total++; if (data_out_b !== 16'hAAAA) $display("FAIL bypass_other_port: got %h expected %h", data_out_b, 16'hAAAA); else n_pass++;
        tick();
        n_total++; if (data_out_a !== 16'h0002) $display("FAIL bypass_post_edge: got %h expected %h", data_out_a, 16'h0002); else n_pass++;
    endtask

    task automatic test_write_no_pending();
        do_write(3'd3, 16'h3333);
        readnum_a = 3'd3; readnum_b = 3'd1;
        #1;
        n_total++; if (data_out_a !== 16'h3333) $display("FAIL plain_write_data: got %h expected %h", data_out_a, 16'h3333); else n_pass++;
        n_total++; if (busy_a !== 1'b0) $display("FAIL plain_write_busy: got %b expected %b", busy_a, 1'b0); else n_pass++;
        n_total++; if (data_out_b !== 16'hAAAA) $display("FAIL other_reg_held: got %h expected %h", data_out_b, 16'hAAAA); else n_pass++;
    endtask

    initial begin
        reset = 1'b0; write = 1'b0; rsv = 1'b0;
        data_in = '0; writenum = '0; rsvnum = '0;
        readnum_a = '0; readnum_b = '0;
        #1;
        test_reset();
        test_dual_read();
        test_scoreboard();
        test_simultaneous();
        test_double_reserve();
        test_bypass();
        test_write_no_pending();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
